// File: rtl/cache_perf_monitor_if.sv
// Tagged-word stream from the cache profiler into the UART/FIFO logging path.
interface cache_perf_monitor_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cache_perf_monitor.sv
// Multi-channel cache-event profiler: counts rising edges per channel, snapshots
// on a cycle schedule or on request, and streams one tagged word per channel.
module cache_perf_monitor #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned FIRST_SNAP    = 500,
  parameter int unsigned PERIOD        = 1000,
  parameter int unsigned NUM_SNAPS     = 3,
  parameter int unsigned SATURATE      = 1,
  parameter int unsigned CLEAR_ON_SNAP = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_CH-1:0]     ev_in,
  input  logic                  snap_req,
  cache_perf_monitor_if.master  out_if,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  localparam int unsigned       CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [31:0]        cyc;
  logic [31:0]        next_snap;
  logic [31:0]        snap_idx;
  logic [NUM_CH-1:0]  prev;
  logic [NUM_CH-1:0]  ev;
  logic [CNT_W-1:0]   cnt  [NUM_CH];
  logic [CNT_W-1:0]   snap [NUM_CH];
  logic [CH_W-1:0]    ch_q, ch_d, ch_nxt;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d, busy_d;
  logic               sched_hit, trig, accept, xfer, last_xfer;

  // Word layout: tag twice, then the zero-extended count.
  function automatic logic [31:0] make_word(input logic [CH_W-1:0] idx,
                                            input logic [CNT_W-1:0] val);
    logic [7:0] tag;
    tag = 8'h61 + 8'(idx);
    return {tag, tag, 16'(val)};
  endfunction

  assign ev        = ev_in & ~prev;
  assign sched_hit = (cyc == next_snap) && ((NUM_SNAPS == 0) || (snap_idx < NUM_SNAPS));
  assign trig      = sched_hit | snap_req;
  assign accept    = trig & ~busy;
  assign xfer      = valid_q & out_if.out_ready;
  assign last_xfer = xfer && (ch_q == LAST_CH);
  assign ch_nxt    = ch_q + CH_W'(1);

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;

  // Free-running cycle count, edge history and the scheduled-snapshot cursor.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc       <= '0;
      prev      <= '0;
      next_snap <= FIRST_SNAP;
      snap_idx  <= '0;
    end else begin
      cyc  <= cyc + 32'd1;
      prev <= ev_in;
      if (sched_hit) begin
        next_snap <= next_snap + PERIOD;
        if (NUM_SNAPS != 0) snap_idx <= snap_idx + 32'd1;
      end
    end
  end

  // Event counters and the snapshot they are frozen into on an accepted trigger.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept) snap[i] <= cnt[i];
        if (accept && (CLEAR_ON_SNAP != 0))
          cnt[i] <= ev[i] ? CNT_W'(1) : '0;
        else if (ev[i] && !((SATURATE != 0) && (cnt[i] == CNT_MAX)))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Triggers that arrive mid-stream are dropped and tallied.
  always_ff @(posedge clk) begin
    if (!rstn)
      overrun_cnt <= '0;
    else if (trig && busy && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  // Stream state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy    <= busy_d;
    end
  end

  // Next-state: leave IDLE on an accepted trigger, return after the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: word 0 comes straight from the live counters, later words from the snapshot.
  always_comb begin
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d    = '0;
          data_d  = make_word(CH_W'(0), cnt[0]);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (last_xfer) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          ch_d   = ch_nxt;
          data_d = make_word(ch_nxt, snap[ch_nxt]);
        end
      end
      default: ;
    endcase
  end

endmodule
